// File: rtl/slave_mode_controller.sv
// ---------------------------------------------------------------------------
// slave_mode_controller
//
// Timer slave-mode controller. It synchronises the selected trigger input,
// detects its edges and drives the counter enable, the counter reinitialise
// pulse and a sticky trigger flag according to the slave mode select.
//
// Ports
//   clk_i       timer kernel clock, all state on the rising edge
//   aresetn_i   asynchronous active-low reset
//   sms_i[2:0]  slave mode: 000 off, 001-011 encoder, 100 reset,
//               101 gated, 110 trigger, 111 external clock 1
//   trgi_i      selected trigger input (level)
//   cen_i       software counter enable (level)
//   opm_i       one-pulse mode enable
//   ovf_i       counter overflow/update pulse
//   tif_clr_i   trigger flag clear pulse
//   cnt_en_o    counter count enable (registered)
//   cnt_rst_o   counter reinitialise pulse (registered, 1 cycle)
//   tif_o       sticky trigger interrupt flag (registered)
//   state_o     FSM state: 00 IDLE, 01 WAIT_TRG, 10 RUN, 11 DONE
//
// Configuration
//   SMC_TRG_SYNC_EN  when defined, a 2-flop synchroniser precedes the trigger
//                    edge detector, adding 2 cycles to every trigger latency.
// ---------------------------------------------------------------------------
module slave_mode_controller (
   input  logic       clk_i,
   input  logic       aresetn_i,
   input  logic [2:0] sms_i,
   input  logic       trgi_i,
   input  logic       cen_i,
   input  logic       opm_i,
   input  logic       ovf_i,
   input  logic       tif_clr_i,
   output logic       cnt_en_o,
   output logic       cnt_rst_o,
   output logic       tif_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_TRG = 2'b01,
      ST_RUN      = 2'b10,
      ST_DONE     = 2'b11
   } state_e;

   localparam logic [2:0] SMS_RESET   = 3'b100;
   localparam logic [2:0] SMS_GATED   = 3'b101;
   localparam logic [2:0] SMS_TRIGGER = 3'b110;
   localparam logic [2:0] SMS_EXTCLK  = 3'b111;

   state_e state_q, state_d;
   logic   trg_src;
   logic   trg_q, trg_qq;
   logic   cnt_en_q, cnt_en_d;
   logic   cnt_rst_q, cnt_rst_d;
   logic   tif_q, tif_d;
   logic   rise, fall, tif_set;

`ifdef SMC_TRG_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], trgi_i};
      end
   end

   assign trg_src = sync_q[1];
`else
   assign trg_src = trgi_i;
`endif

   // Edge detector; trg_q also serves as the gated-mode level.
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         trg_q  <= 1'b0;
         trg_qq <= 1'b0;
      end else begin
         trg_q  <= trg_src;
         trg_qq <= trg_q;
      end
   end

   assign rise = trg_q & ~trg_qq;
   assign fall = ~trg_q & trg_qq;

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q   <= ST_IDLE;
         cnt_en_q  <= 1'b0;
         cnt_rst_q <= 1'b0;
         tif_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_en_q  <= cnt_en_d;
         cnt_rst_q <= cnt_rst_d;
         tif_q     <= tif_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sms_i == SMS_TRIGGER) begin
               state_d = ST_WAIT_TRG;
            end else if (cen_i) begin
               state_d = ST_RUN;
            end
         end
         ST_WAIT_TRG: begin
            if (rise) begin
               state_d = ST_RUN;
            end else if (sms_i != SMS_TRIGGER) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (opm_i && ovf_i) begin
               state_d = ST_DONE;
            end else if (!cen_i && (sms_i != SMS_TRIGGER)) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!cen_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The enable is registered from the next state so that it changes in the
   // same cycle as state_o (e.g. drops together with the move to DONE).
   always_comb begin
      cnt_en_d = 1'b0;
      if (state_d == ST_RUN) begin
         unique case (sms_i)
            SMS_GATED:  cnt_en_d = trg_q;
            SMS_EXTCLK: cnt_en_d = rise;
            default:    cnt_en_d = 1'b1;
         endcase
      end
   end

   always_comb begin
      cnt_rst_d = (sms_i == SMS_RESET) && rise;

      tif_set = 1'b0;
      unique case (sms_i)
         SMS_RESET, SMS_TRIGGER, SMS_EXTCLK: tif_set = rise;
         SMS_GATED:                          tif_set = rise | fall;
         default:                            tif_set = 1'b0;
      endcase

      // A set in the same cycle as a clear keeps the flag high.
      tif_d = tif_set | (tif_q & ~tif_clr_i);
   end

   assign cnt_en_o  = cnt_en_q;
   assign cnt_rst_o = cnt_rst_q;
   assign tif_o     = tif_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_slave_mode_controller.sv
module tb_slave_mode_controller;

`ifdef SMC_TRG_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk_i = 1'b0;
   logic       aresetn_i = 1'b0;
   logic [2:0] sms_i = '0;
   logic       trgi_i = 1'b0;
   logic       cen_i = 1'b0;
   logic       opm_i = 1'b0;
   logic       ovf_i = 1'b0;
   logic       tif_clr_i = 1'b0;
   logic       cnt_en_o, cnt_rst_o, tif_o;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;

   // Reference model: trigger samples kept as a history list, newest first.
   bit hist[$];
   int m_state;
   bit m_en, m_rst, m_tif;

   slave_mode_controller dut (
      .clk_i     (clk_i),
      .aresetn_i (aresetn_i),
      .sms_i     (sms_i),
      .trgi_i    (trgi_i),
      .cen_i     (cen_i),
      .opm_i     (opm_i),
      .ovf_i     (ovf_i),
      .tif_clr_i (tif_clr_i),
      .cnt_en_o  (cnt_en_o),
      .cnt_rst_o (cnt_rst_o),
      .tif_o     (tif_o),
      .state_o   (state_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic bit samp(int k);
      return (k < hist.size()) ? hist[k] : 1'b0;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_state = 0;
      m_en = 0;
      m_rst = 0;
      m_tif = 0;
   endtask

   // Applies the mode rules for one rising edge using the inputs as driven.
   task automatic model_edge();
      bit lvl, prev, rise, fall, set;
      int n;
      lvl  = samp(LAT - 1);
      prev = samp(LAT);
      rise = lvl && !prev;
      fall = !lvl && prev;
      n = m_state;
      if (m_state == 0) begin
         if (sms_i == 6) n = 1;
         else if (cen_i) n = 2;
      end else if (m_state == 1) begin
         if (rise) n = 2;
         else if (sms_i != 6) n = 0;
      end else if (m_state == 2) begin
         if (opm_i && ovf_i) n = 3;
         else if (!cen_i && sms_i != 6) n = 0;
      end else begin
         if (!cen_i) n = 0;
      end
      m_state = n;
      if (n != 2) m_en = 0;
      else if (sms_i == 5) m_en = lvl;
      else if (sms_i == 7) m_en = rise;
      else m_en = 1;
      m_rst = (sms_i == 4) && rise;
      if (sms_i == 5) set = rise || fall;
      else if (sms_i >= 4) set = rise;
      else set = 0;
      m_tif = set || (m_tif && !tif_clr_i);
      hist.push_front(trgi_i);
      if (hist.size() > 8) void'(hist.pop_back());
   endtask

   task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".state"}, state_o, 2'(m_state));
      chk({tag, ".en"}, {1'b0, cnt_en_o}, {1'b0, m_en});
      chk({tag, ".rst"}, {1'b0, cnt_rst_o}, {1'b0, m_rst});
      chk({tag, ".tif"}, {1'b0, tif_o}, {1'b0, m_tif});
   endtask

   task automatic step(string tag);
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      chk_model(tag);
   endtask

   // Called just after a falling edge: asserts reset between edges and
   // checks that the outputs clear without waiting for the clock.
   task automatic do_reset();
      #2 aresetn_i = 1'b0;
      #1;
      chk("rst_async.state", state_o, 2'b00);
      chk("rst_async.en", {1'b0, cnt_en_o}, 2'b00);
      chk("rst_async.rst", {1'b0, cnt_rst_o}, 2'b00);
      chk("rst_async.tif", {1'b0, tif_o}, 2'b00);
      model_reset();
      @(negedge clk_i);
      aresetn_i = 1'b1;
   endtask

   initial begin
      int en_hi, en_edges;
      bit en_prev;
      int hold;

      model_reset();
      // Power-on reset
      @(negedge clk_i);
      @(negedge clk_i);
      chk_model("por");
      aresetn_i = 1'b1;

      // Free-running mode: cen_i alone starts and stops the counter
      sms_i = 3'b000; cen_i = 1'b1;
      step("free_on");
      chk("free_on.state_c", state_o, 2'b10);
      chk("free_on.en_c", {1'b0, cnt_en_o}, 2'b01);
      cen_i = 1'b0;
      step("free_off");
      chk("free_off.state_c", state_o, 2'b00);
      chk("free_off.en_c", {1'b0, cnt_en_o}, 2'b00);

      // Trigger mode with one-pulse stop
      sms_i = 3'b110;
      step("trg_arm");
      chk("trg_arm.state_c", state_o, 2'b01);
      for (int i = 0; i < 3; i++) step("trg_wait");
      trgi_i = 1'b1;
      for (int i = 0; i < LAT; i++) step("trg_lat");
      chk("trg_lat.state_c", state_o, 2'b01);
      step("trg_go");
      chk("trg_go.state_c", state_o, 2'b10);
      chk("trg_go.tif_c", {1'b0, tif_o}, 2'b01);
      for (int i = 0; i < 5; i++) step("trg_run");
      opm_i = 1'b1; ovf_i = 1'b1;
      step("trg_opm");
      chk("trg_opm.state_c", state_o, 2'b11);
      chk("trg_opm.en_c", {1'b0, cnt_en_o}, 2'b00);
      ovf_i = 1'b0; opm_i = 1'b0; trgi_i = 1'b0;
      step("trg_done");

      // Asynchronous abort of a running counter
      do_reset();
      sms_i = 3'b000; cen_i = 1'b1;
      step("rerun");
      step("rerun");
      do_reset();

      // Reset mode: each rise gives one cnt_rst_o pulse; set beats clear
      sms_i = 3'b100; cen_i = 1'b1;
      step("rm_idle");
      for (int p = 0; p < 2; p++) begin
         trgi_i = 1'b1;
         for (int i = 0; i < LAT; i++) step("rm_lat");
         tif_clr_i = 1'b1;
         step("rm_pulse");
         chk("rm_pulse.rst_c", {1'b0, cnt_rst_o}, 2'b01);
         chk("rm_pulse.tif_c", {1'b0, tif_o}, 2'b01);
         tif_clr_i = 1'b0;
         step("rm_after");
         chk("rm_after.rst_c", {1'b0, cnt_rst_o}, 2'b00);
         trgi_i = 1'b0;
         for (int i = 0; i < 6; i++) step("rm_gap");
      end

      // Gated mode: enable follows the trigger level, flag on both edges
      do_reset();
      sms_i = 3'b101; cen_i = 1'b1;
      step("gate_idle");
      en_hi = 0;
      trgi_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) tif_clr_i = 1'b1;
         step("gate_hi");
         tif_clr_i = 1'b0;
         en_hi += int'(cnt_en_o);
      end
      trgi_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step("gate_lo");
         en_hi += int'(cnt_en_o);
      end
      chk("gate.en_cycles", 2'(en_hi == 10), 2'b01);
      chk("gate.tif_fall", {1'b0, tif_o}, 2'b01);

      // External clock: one single-cycle enable per trigger rise
      sms_i = 3'b111; tif_clr_i = 1'b1;
      step("ext_idle");
      tif_clr_i = 1'b0;
      en_hi = 0; en_edges = 0; en_prev = 0;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 5; i++) begin
            trgi_i = (i < 2);
            step("ext");
            en_hi += int'(cnt_en_o);
            if (cnt_en_o && !en_prev) en_edges++;
            en_prev = cnt_en_o;
         end
      end
      trgi_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("ext_tail");
         en_hi += int'(cnt_en_o);
         if (cnt_en_o && !en_prev) en_edges++;
         en_prev = cnt_en_o;
      end
      chk("ext.pulses", 2'(en_edges == 4), 2'b01);
      chk("ext.en_cycles", 2'(en_hi == 4), 2'b01);

      // Randomised traffic against the model
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if (hold == 0) begin
            trgi_i = ~trgi_i;
            hold = $urandom_range(1, 5);
         end
         hold--;
         if ($urandom_range(0, 15) == 0) sms_i = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) cen_i = ~cen_i;
         opm_i     = ($urandom_range(0, 3) != 0);
         ovf_i     = ($urandom_range(0, 11) == 0);
         tif_clr_i = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         else step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slave_mode_controller.md
SLAVE_MODE_CONTROLLER -- requirements
Module: slave_mode_controller

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk_i  input  1  timer kernel clock; all state on rising edge.
REQ-003 aresetn_i  input  1  reset, asynchronous, active-low.
REQ-004 sms_i  input  3  slave mode select: 000 off, 001-011 encoder, 100 reset, 101 gated, 110 trigger, 111 ext clock 1.
REQ-005 trgi_i  input  1  selected trigger input (TRGI), level.
REQ-006 cen_i  input  1  software counter enable, level.
REQ-007 opm_i  input  1  one-pulse mode enable.
REQ-008 ovf_i  input  1  counter overflow/update pulse, 1 cycle.
REQ-009 tif_clr_i  input  1  trigger flag clear pulse.
REQ-010 cnt_en_o  output  1  counter count enable, registered.
REQ-011 cnt_rst_o  output  1  counter reinitialise pulse, registered, 1 cycle.
REQ-012 tif_o  output  1  sticky trigger interrupt flag, registered.
REQ-013 state_o  output  2  FSM state: 00 IDLE, 01 WAIT_TRG, 10 RUN, 11 DONE.

Function
REQ-014 trgi_i is registered twice (trg_q, trg_qq); rise = trg_q & ~trg_qq, fall = ~trg_q & trg_qq.
REQ-015 IDLE: sms_i=110 -> WAIT_TRG; else cen_i=1 -> RUN; else stay.
REQ-016 WAIT_TRG: rise -> RUN; sms_i!=110 -> IDLE; rise has priority.
REQ-017 RUN: opm_i & ovf_i -> DONE; else cen_i=0 and sms_i!=110 -> IDLE; else stay.
REQ-018 DONE: cen_i=0 -> IDLE; else stay. In trigger mode, the next trigger is accepted only after passing through IDLE to WAIT_TRG.
REQ-019 cnt_en_o = 0 outside RUN. In RUN:
- sms 101: trg_q.
- sms 111: rise.
- otherwise: 1.
REQ-020 Gated and ext-clock enables appear 2 cycles after trgi_i is sampled; the ext-clock enable pulse is exactly 1 cycle per trgi_i rising edge.
REQ-021 sms 100, any state: rise -> cnt_rst_o=1 on the following cycle, for 1 cycle.
REQ-022 cnt_rst_o is never asserted in any other mode.
REQ-023 tif_o sets on rise in sms 100/110/111, and on rise or fall in sms 101; it never sets in sms 000-011.
REQ-024 Simultaneous set and tif_clr_i: set wins.
REQ-025 Simultaneous rise (sms 100) and opm_i & ovf_i in RUN: FSM -> DONE and cnt_rst_o still pulses.
REQ-026 Rise while RUN in sms 110: no state change; tif_o sets.
REQ-027 sms_i change while RUN: the new mode's enable rule applies on the next cycle; no spurious cnt_rst_o.
REQ-028 Trigger events with trgi_i pulses narrower than 1 clk_i period are not guaranteed detected.

Reset
REQ-029 aresetn_i low: state_o=00, cnt_en_o=0, cnt_rst_o=0, tif_o=0, trg_q=trg_qq=0, immediately and asynchronously.
REQ-030 Reset mid-RUN aborts without a cnt_rst_o pulse.
REQ-031 The first rise after reset is detectable 2 cycles after deassertion if trgi_i is high.

Configuration
REQ-032 Macro SMC_TRG_SYNC_EN defined: a 2-flop synchroniser, reset to 0, precedes trg_q. All trigger-derived latencies grow by 2 cycles.
REQ-033 SMC_TRG_SYNC_EN undefined: trgi_i feeds trg_q directly; latencies are as in REQ-020/021.

Verification
REQ-034 sms=000, cen_i 0->1 -> state 10 next cycle, cnt_en_o=1; cen_i->0 -> state 00, cnt_en_o=0.
REQ-035 sms=110, cen_i=0, trgi_i rises at cycle 10 -> state 01 before, 10 at cycle 12, tif_o=1. With opm_i=1, ovf_i at cycle 20 -> state 11, cnt_en_o=0 at cycle 21.
REQ-036 sms=100, cen_i=1, trgi_i rising at cycles 5 and 15 -> cnt_rst_o single-cycle pulses at cycles 7 and 17. tif_clr_i at cycle 17 -> tif_o stays 1 (set wins).
REQ-037 sms=101, cen_i=1, trgi_i high cycles 10-19 -> cnt_en_o high cycles 12-21, tif_o set at 12, cleared by tif_clr_i at 14, set again at 22.
REQ-038 sms=111, cen_i=1, 4 trgi_i pulses, 2 cycles high / 3 low -> exactly 4 single-cycle cnt_en_o pulses.
REQ-039 Assert aresetn_i low mid-RUN -> all outputs 0 asynchronously. Repeat REQ-035 with SMC_TRG_SYNC_EN -> RUN at cycle 14.
